// File: rtl/prio_sel_if.sv
// prio_sel_if: bus bundle for prio_sel_reg.
//   sel     : per-channel select, bit 0 highest priority
//   vals    : packed channel values, channel i at [i*W +: W]
//   clr     : synchronous clear
//   out     : registered selected value
//   out_idx : registered winning channel index
//   out_vld : registered, 1 when out holds a captured channel value
//   busy    : 1 while a dwell is in progress and inputs are ignored
// master drives the selects/values, slave is the selector itself.
interface prio_sel_if #(
    parameter int N = 4,
    parameter int W = 3
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    sel;
    logic [N*W-1:0]  vals;
    logic            clr;
    logic [W-1:0]    out;
    logic [IDXW-1:0] out_idx;
    logic            out_vld;
    logic            busy;

    modport master (output sel, vals, clr, input out, out_idx, out_vld, busy);
    modport slave  (input sel, vals, clr, output out, out_idx, out_vld, busy);
endinterface

// File: rtl/prio_sel_reg.sv
// prio_sel_reg: N-channel priority selector with registered output.
// The lowest-index asserted select wins; its value and index are registered.
// With no select the output returns to DEFAULT_VAL.
// Optional macro PRIO_SEL_DWELL_EN: after a capture the output is frozen
// for HOLD cycles (inputs ignored, busy=1) before re-evaluation.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : prio_sel_if slave (sel, vals, clr in; out, out_idx, out_vld, busy out)
module prio_sel_reg #(
    parameter int           N           = 4,
    parameter int           W           = 3,
    parameter logic [W-1:0] DEFAULT_VAL = '0,
    parameter int           HOLD        = 3
) (
    input  logic      clk,
    input  logic      rst,
    prio_sel_if.slave bus
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    // Priority pick: scan from the top down so the lowest index wins last.
    logic            hit;
    logic [IDXW-1:0] win_idx;
    logic [W-1:0]    win_val;

    always_comb begin
        hit     = 1'b0;
        win_idx = '0;
        win_val = DEFAULT_VAL;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.sel[i]) begin
                hit     = 1'b1;
                win_idx = IDXW'(i);
                win_val = bus.vals[i*W +: W];
            end
        end
    end

    logic [W-1:0]    out_q,   out_nx;
    logic [IDXW-1:0] idx_q,   idx_nx;
    logic            vld_q,   vld_nx;

`ifdef PRIO_SEL_DWELL_EN
    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic {IDLE, DWELL} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt,   cnt_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        out_nx   = out_q;
        idx_nx   = idx_q;
        vld_nx   = vld_q;
        if (bus.clr) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            out_nx   = DEFAULT_VAL;
            idx_nx   = '0;
            vld_nx   = 1'b0;
        end else if (state == DWELL) begin
            // Output frozen; leaving at cnt==1 keeps cnt from wrapping.
            cnt_nx = cnt - CW'(1);
            if (cnt == CW'(1))
                state_nx = IDLE;
        end else begin
            out_nx = win_val;
            idx_nx = win_idx;
            vld_nx = hit;
            if (hit && (HOLD > 1)) begin
                cnt_nx   = CW'(HOLD - 1);
                state_nx = DWELL;
            end
        end
    end

    assign bus.busy = (state == DWELL);
`else
    always_comb begin
        out_nx = win_val;
        idx_nx = win_idx;
        vld_nx = hit;
        if (bus.clr) begin
            out_nx = DEFAULT_VAL;
            idx_nx = '0;
            vld_nx = 1'b0;
        end
    end

    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= DEFAULT_VAL;
            idx_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_nx;
            idx_q <= idx_nx;
            vld_q <= vld_nx;
        end
    end

    assign bus.out     = out_q;
    assign bus.out_idx = idx_q;
    assign bus.out_vld = vld_q;
endmodule
